// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared digit type and 7-segment codes for the scanned BCD display.
package bcd_disp_pkg;
    localparam int NUM_DIGITS = 6;
    typedef logic [3:0] bcd_digit_t;
    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] pattern
);
    always_comb begin
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: double-buffered 6-digit multiplexed 7-segment driver with
// leading-zero blanking; new values swap in only at frame boundaries.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] ones_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] hundreds_i,
    input  logic [3:0] thousands_i,
    input  logic [3:0] ten_thousands_i,
    input  logic       hundred_thousands_i,
    input  logic       blank_i,
    output logic [6:0] seg_o,
    output logic [5:0] an_o,
    output logic       pending_o
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0] AN_POL = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic [PW-1:0] prescaler;
    logic [2:0] idx;
    bcd_digit_t in_digits [NUM_DIGITS];
    bcd_digit_t shadow [NUM_DIGITS];
    bcd_digit_t disp [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_run;
    logic tick, frame_end, blanked, off;
    bcd_digit_t cur;
    logic [6:0] pattern;

    assign in_digits = '{ones_i, tens_i, hundreds_i, thousands_i, ten_thousands_i,
                         {3'b000, hundred_thousands_i}};
    assign tick = prescaler == LAST;
    assign frame_end = tick && idx == 3'(NUM_DIGITS - 1);
    assign cur = disp[idx];

    // zero_run[n]: disp digits n..5 are all zero
    always_comb begin
        logic z;
        z = 1'b1;
        zero_run = '0;
        for (int n = NUM_DIGITS - 1; n >= 0; n--) begin
            z = z && disp[n] == 4'd0;
            zero_run[n] = z;
        end
    end

    assign blanked = BLANK_LZ && idx != 3'd0 && zero_run[idx];
    assign off = blank_i || blanked;

    seg7_decode u_dec (.digit(cur), .pattern(pattern));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
            shadow    <= '{default: '0};
            disp      <= '{default: '0};
            pending_o <= 1'b0;
            seg_o     <= SEG_OFF ^ SEG_POL;
            an_o      <= AN_POL;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            if (load_i) shadow <= in_digits;
            // A load landing on frame_end bypasses the shadow entirely
            if (frame_end && (pending_o || load_i)) begin
                disp      <= load_i ? in_digits : shadow;
                pending_o <= 1'b0;
            end else if (load_i) begin
                pending_o <= 1'b1;
            end
            seg_o <= (off ? SEG_OFF : pattern) ^ SEG_POL;
            an_o  <= (off ? 6'd0 : 6'd1 << idx) ^ AN_POL;
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed checks of scan timing, buffering, blanking and reset
// on a fast-refresh instance plus a no-blanking companion instance.
module tb_bcd_scan_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_i = 1'b0;
    logic [3:0] ones_i = '0, tens_i = '0, hundreds_i = '0, thousands_i = '0, ten_thousands_i = '0;
    logic hundred_thousands_i = 1'b0;
    logic blank_i = 1'b0;
    logic [6:0] seg_o, seg2;
    logic [5:0] an_o, an2;
    logic pending_o, pending2;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .ones_i(ones_i), .tens_i(tens_i),
        .hundreds_i(hundreds_i), .thousands_i(thousands_i), .ten_thousands_i(ten_thousands_i),
        .hundred_thousands_i(hundred_thousands_i), .blank_i(blank_i),
        .seg_o(seg_o), .an_o(an_o), .pending_o(pending_o));

    bcd_scan_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .ones_i(ones_i), .tens_i(tens_i),
        .hundreds_i(hundreds_i), .thousands_i(thousands_i), .ten_thousands_i(ten_thousands_i),
        .hundred_thousands_i(hundred_thousands_i), .blank_i(blank_i),
        .seg_o(seg2), .an_o(an2), .pending_o(pending2));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h want %02h", tag, got, want);
        end
    endtask

    // cyc counts edges since reset release; outputs now reflect idx of edge cyc-1
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    task automatic show(input int d);
        while (((cyc - 1) / 4) % 6 != d) step();
    endtask

    task automatic load(input logic [3:0] d0, d1, d2, d3, d4, input logic d5);
        {ones_i, tens_i, hundreds_i, thousands_i, ten_thousands_i, hundred_thousands_i} = {d0, d1, d2, d3, d4, d5};
        load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    task automatic digit(input string tag, input logic [5:0] an_w, input logic [6:0] seg_w);
        check({tag, " an"}, {2'b0, an_o}, {2'b0, an_w});
        check({tag, " seg"}, {1'b0, seg_o}, {1'b0, seg_w});
    endtask

    initial begin
        #12;
        check("rst an", {2'b0, an_o}, 8'h3F);
        check("rst seg", {1'b0, seg_o}, 8'h7F);
        check("rst pend", {7'b0, pending_o}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        step();
        digit("zero d0 first", 6'h3E, 7'h40);
        run_to(4);
        digit("zero d0 held", 6'h3E, 7'h40);
        step();
        digit("zero d1 blank", 6'h3F, 7'h7F);
        check("nolz zero d1 an", {2'b0, an2}, 8'h3D);
        // digits 6,5,5,3,6,0 loaded mid-frame
        run_to(10);
        load(4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 1'b0);
        check("pend set", {7'b0, pending_o}, 8'h01);
        run_to(23);
        check("pend hold", {7'b0, pending_o}, 8'h01);
        step();
        check("pend clr", {7'b0, pending_o}, 8'h00);
        show(0); digit("v6 d0", 6'h3E, 7'h02);
        show(1); digit("v6 d1", 6'h3D, 7'h12);
        show(2); digit("v6 d2", 6'h3B, 7'h12);
        show(3); digit("v6 d3", 6'h37, 7'h30);
        show(4); digit("v6 d4", 6'h2F, 7'h02);
        show(5); digit("v6 d5", 6'h3F, 7'h7F);
        check("nolz v6 d5 an", {2'b0, an2}, 8'h1F);
        // value 100
        load(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        show(0); digit("v100 d0", 6'h3E, 7'h40);
        show(1); digit("v100 d1", 6'h3D, 7'h40);
        show(2); digit("v100 d2", 6'h3B, 7'h79);
        show(3); digit("v100 d3", 6'h3F, 7'h7F);
        check("nolz v100 d3 an", {2'b0, an2}, 8'h37);
        check("nolz v100 d3 seg", {1'b0, seg2}, 8'h40);
        show(4); digit("v100 d4", 6'h3F, 7'h7F);
        check("nolz v100 d4 an", {2'b0, an2}, 8'h2F);
        show(5); digit("v100 d5", 6'h3F, 7'h7F);
        check("nolz v100 d5 an", {2'b0, an2}, 8'h1F);
        // two loads in one frame: last wins
        run_to(74);
        load(4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 1'b0);
        run_to(80);
        load(4'd8, 4'd7, 4'd6, 4'd5, 4'd0, 1'b0);
        check("pend two", {7'b0, pending_o}, 8'h01);
        show(0); digit("v5678 d0", 6'h3E, 7'h00);
        show(1); digit("v5678 d1", 6'h3D, 7'h78);
        show(2); digit("v5678 d2", 6'h3B, 7'h02);
        show(3); digit("v5678 d3", 6'h37, 7'h12);
        show(4); digit("v5678 d4", 6'h3F, 7'h7F);
        // load on the frame_end edge goes straight to disp
        run_to(119);
        load(4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        check("pend fe", {7'b0, pending_o}, 8'h00);
        show(0); digit("v100009 d0", 6'h3E, 7'h10);
        show(2); digit("v100009 d2", 6'h3B, 7'h40);
        show(4); digit("v100009 d4", 6'h2F, 7'h40);
        show(5); digit("v100009 d5", 6'h1F, 7'h79);
        check("pend fe late", {7'b0, pending_o}, 8'h00);
        // non-decimal digit shows dash; then blanking
        load(4'hB, 4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
        show(0); digit("dash d0", 6'h3E, 7'h3F);
        blank_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0 || i == 9) begin
                digit("blank", 6'h3F, 7'h7F);
                check("nolz blank an", {2'b0, an2}, 8'h3F);
            end
        end
        blank_i = 1'b0;
        step();
        digit("resume d2", 6'h3B, 7'h40);
        show(4); digit("resume d4", 6'h2F, 7'h78);
        // reset while a load is pending at idx 3
        run_to(170);
        load(4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        show(3);
        digit("pre rst d3", 6'h37, 7'h40);
        check("pre rst pend", {7'b0, pending_o}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        digit("async rst", 6'h3F, 7'h7F);
        check("async rst pend", {7'b0, pending_o}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        step();
        digit("post rst d0", 6'h3E, 7'h40);
        run_to(25);
        digit("post rst next frame", 6'h3E, 7'h40);
        check("post rst pend", {7'b0, pending_o}, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
